// File: rtl/serial_parity_checker.sv
// Serial parity checker: reassembles an LSB-first frame of DATA_W bits plus
// one parity bit. Optional error counter under PARITY_ERR_CNT_EN.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              frame_clr,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              parity_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    localparam logic ODD_B = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic              pe_q, pe_d;
    logic              pe_new;
`ifdef PARITY_ERR_CNT_EN
    logic [15:0]       ec_q, ec_d;
`endif

    assign pe_new = ((acc_q ^ in_bit) != ODD_B);

    // Next-state, bit assembly and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        ov_d    = 1'b0;
        od_d    = od_q;
        pe_d    = pe_q;
`ifdef PARITY_ERR_CNT_EN
        ec_d    = ec_q;
`endif
        if (frame_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    sh_d[0] = in_bit;
                    acc_d   = in_bit;
                    cnt_d   = CNT_W'(1);
                    state_d = DATA;
                end
                DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            sh_d[i] = in_bit;
                        end
                    end
                    acc_d = acc_q ^ in_bit;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    ov_d    = 1'b1;
                    od_d    = sh_q;
                    pe_d    = pe_new;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    state_d = IDLE;
`ifdef PARITY_ERR_CNT_EN
                    if (pe_new && (ec_q != 16'hFFFF)) begin
                        ec_d = ec_q + 16'd1;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            sh_q    <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            pe_q    <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
            ec_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            pe_q    <= pe_d;
`ifdef PARITY_ERR_CNT_EN
            ec_q    <= ec_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign parity_err = pe_q;
`ifdef PARITY_ERR_CNT_EN
    assign err_count  = ec_q;
`endif

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive-side companion to the parity generator: accepts a serial frame of `DATA_W` data bits, LSB first, followed by one parity bit. It reassembles the data word and checks the received parity bit against the configured parity sense. It reports the word and a parity-error flag with a single-cycle valid pulse. It sits at the receiving end of any link whose transmitter appends a generated parity bit.

## Interface
Parameters:
- `DATA_W`, 8: number of data bits per frame (legal range 2..32).
- `ODD`, 0: parity sense. 0 = even parity (the XOR of data and parity equals 0); 1 = odd parity (that XOR equals 1).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  qualifies `in_bit` this cycle.
- `in_bit`  in  1  serial frame bit.
- `frame_clr`  in  1  synchronous abort; discards any partial frame.
- `busy`  out  1  high while a frame is partially received.
- `out_valid`  out  1  one-cycle pulse when a complete frame has been checked.
- `out_data`  out  DATA_W  reassembled data word; valid while `out_valid` is high, holds its value otherwise.
- `parity_err`  out  1  parity mismatch for the frame; valid with `out_valid`, holds its value otherwise.
- `err_count`  out  16  saturating count of bad frames (present only under `PARITY_ERR_CNT_EN`).

## Operation
State machine with three states:
- **IDLE**: `bit_cnt` = 0 and the accumulator is cleared. On `in_valid`, store `in_bit` at `out_data` shift-register bit 0, set `acc = in_bit`, and go to DATA.
- **DATA**: on each `in_valid`, store `in_bit` at position `bit_cnt` and update `acc ^= in_bit`. After the `DATA_W`-th data bit is accepted, go to PARITY.
- **PARITY**: on `in_valid`, compute `parity_err <= (acc ^ in_bit) != ODD`. Load `out_data` from the shift register, pulse `out_valid` on the next cycle, and return to IDLE.

Rules:
- `in_valid` low stalls the FSM in place; gaps of any length are allowed anywhere in the frame.
- `busy` = (state != IDLE).
- `frame_clr` returns the FSM to IDLE and clears `bit_cnt` and `acc`. It does not alter `out_data`, `parity_err`, or `err_count`. It has priority over `in_valid` in the same cycle, so that bit is dropped.
- `frame_clr` in the cycle the parity bit is accepted: the frame is discarded and no `out_valid` is produced.
- Internal `bit_cnt` width is $clog2(DATA_W+1).

## Timing
- Reset values: `busy` = 0, `out_valid` = 0, `out_data` = 0, `parity_err` = 0, `err_count` = 0, FSM in IDLE.
- Reset asserted mid-frame aborts the frame immediately. No `out_valid` is produced for it.
- Latency: `out_valid` rises in the first cycle after the edge that sampled the parity bit, and lasts exactly 1 cycle.
- Back-to-back frames: the first data bit of the next frame may be presented in the cycle in which `out_valid` is high. It is accepted with no lost cycle.
- Minimum frame duration is `DATA_W`+1 cycles. Maximum throughput is one frame per `DATA_W`+1 cycles.
- `out_data` and `parity_err` update only on the edge that raises `out_valid`.

## Configuration
- `PARITY_ERR_CNT_EN` defined:
  - `err_count` port and a 16-bit counter are compiled in.
  - The counter increments on the edge that raises `out_valid` with `parity_err` = 1.
  - It saturates at 16'hFFFF with no wrap.
  - It is cleared only by `rst`.
- `PARITY_ERR_CNT_EN` undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- Configuration `DATA_W`=8, `ODD`=0. Send data 0xA5 LSB first with parity bit 0 and no gaps → after the 9th bit, `out_valid` is a 1-cycle pulse with `out_data`=0xA5 and `parity_err`=0.
- Same configuration. Send data 0xA5 with parity bit 1 → `parity_err`=1, and `err_count` goes 0→1 when the macro is defined.
- Configuration `ODD`=1. Send 0x07 with parity 0 → `parity_err`=0. Send 0x07 with parity 1 → `parity_err`=1.
- Send 0x3C and 0xFF back-to-back, each with correct even parity (0 for both), with the second frame's first bit coincident with the first `out_valid` → two pulses 9 cycles apart, with `out_data`=0x3C then 0xFF and both `parity_err`=0.
- Send 4 bits of a frame, then assert `frame_clr` together with `in_valid` → `busy` = 0 and no `out_valid`. A following complete frame 0x81 with parity 0 decodes as 0x81 with `parity_err`=0.
- Insert random `in_valid` gaps (1–5 cycles) inside frame 0x5A with parity 0 → result identical to the gap-free case. Then assert `rst` mid-frame → all outputs return to their reset values and no `out_valid` is produced.
